// File: rtl/store_buffer_fwd_pkg.sv
// Shared types and helpers for the store buffer: entry layout, access-size
// encodings and the byte-enable mask builder used for both stores and loads.
package store_buffer_fwd_pkg;

    localparam int STORE_BUFFER_ENTRIES = 4;
    localparam int SB_ROB_ENTRY_WIDTH   = 4;
    localparam int SB_WORD_SIZE         = 32;
    localparam int SB_MASK_W            = SB_WORD_SIZE / 8;

    localparam logic [2:0] FUNCT3_BYTE = 3'b000;
    localparam logic [2:0] FUNCT3_HALF = 3'b001;
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    typedef struct packed {
        logic                          valid;
        logic                          committed;
        logic [SB_WORD_SIZE-3:0]       waddr;
        logic [SB_WORD_SIZE-1:0]       data;
        logic [SB_MASK_W-1:0]          mask;
        logic [SB_ROB_ENTRY_WIDTH-1:0] rob_id;
    } sb_entry_t;

    // Byte enables for an access of the given size at byte offset off;
    // funct3[2] is the load signedness bit and does not change the footprint.
    function automatic logic [SB_MASK_W-1:0] size_to_mask(input logic [2:0] funct3,
                                                          input logic [1:0] off);
        logic [SB_MASK_W-1:0] mask;
        case (funct3 & 3'b011)
            FUNCT3_BYTE: mask = SB_MASK_W'(1) << off;
            FUNCT3_HALF: mask = SB_MASK_W'(3) << off;
            FUNCT3_WORD: mask = '1;
            default:     mask = '1;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/store_buffer_fwd_match.sv
// Load-forwarding lookup: scans the buffer from oldest to youngest and keeps
// the youngest entry whose word address matches and whose bytes overlap the load.
module sb_fwd_match
    import store_buffer_fwd_pkg::*;
#(
    parameter int DEPTH = STORE_BUFFER_ENTRIES,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  sb_entry_t               entries [DEPTH],
    input  logic [IDX_W-1:0]        head,
    input  logic                    ld_valid,
    input  logic [SB_WORD_SIZE-3:0] ld_waddr,
    input  logic [SB_MASK_W-1:0]    ld_mask,
    output logic                    hit,
    output logic                    partial,
    output logic [SB_WORD_SIZE-1:0] data
);

    logic [IDX_W-1:0]        scan_idx;
    logic                    found;
    logic [SB_MASK_W-1:0]    sel_mask;
    logic [SB_WORD_SIZE-1:0] sel_data;
    logic                    full_cover;
    logic                    unused_fields;

    // Age-ordered priority select: later (younger) matches overwrite earlier ones
    always_comb begin
        scan_idx = '0;
        found    = 1'b0;
        sel_mask = '0;
        sel_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + IDX_W'(i);
            if (entries[scan_idx].valid &&
                (entries[scan_idx].waddr == ld_waddr) &&
                ((entries[scan_idx].mask & ld_mask) != '0)) begin
                found    = 1'b1;
                sel_mask = entries[scan_idx].mask;
                sel_data = entries[scan_idx].data;
            end
        end
        full_cover = ((sel_mask & ld_mask) == ld_mask);
        hit        = ld_valid && found && full_cover;
        partial    = ld_valid && found && !full_cover;
        data       = hit ? sel_data : '0;
    end

    // Commit state and ROB tags play no part in forwarding; fold them into a sink
    always_comb begin
        unused_fields = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            unused_fields = unused_fields ^ (^{entries[i].committed, entries[i].rob_id});
        end
    end

endmodule

// File: rtl/store_buffer_fwd.sv
// In-order store buffer: accepts speculative stores, marks them committed by
// ROB tag, drains committed stores from the head to the D-cache, forwards to
// younger loads and rolls the tail back over uncommitted entries on flush.
module store_buffer_fwd
    import store_buffer_fwd_pkg::*;
#(
    parameter int WORD_SIZE       = SB_WORD_SIZE,
    parameter int DEPTH           = STORE_BUFFER_ENTRIES,
    parameter int ROB_ENTRY_WIDTH = SB_ROB_ENTRY_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [WORD_SIZE-1:0]       st_addr,
    input  logic [WORD_SIZE-1:0]       st_data,
    input  logic [2:0]                 st_funct3,
    input  logic [ROB_ENTRY_WIDTH-1:0] st_rob_id,
    input  logic                       commit_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id,
    input  logic                       flush,
    input  logic                       ld_valid,
    input  logic [WORD_SIZE-1:0]       ld_addr,
    input  logic [2:0]                 ld_funct3,
    output logic                       fwd_hit,
    output logic [WORD_SIZE-1:0]       fwd_data,
    output logic                       fwd_stall,
    output logic                       drain_valid,
    input  logic                       drain_ready,
    output logic [WORD_SIZE-1:0]       drain_addr,
    output logic [WORD_SIZE-1:0]       drain_data,
    output logic [WORD_SIZE/8-1:0]     drain_mask,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    sb_entry_t             entries_q [DEPTH];
    sb_entry_t             entries_d [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [IDX_W-1:0]      head_idx, tail_idx, scan_idx;
    logic [PTR_W-1:0]      occupancy;
    logic                  drain_fire;
    logic                  rollback_found;
    logic [SB_MASK_W-1:0]  st_mask, ld_mask;
    logic [WORD_SIZE-1:0]  st_shift, st_lane;

    // Occupancy flags and the drain port, all from registered state only
    always_comb begin
        head_idx    = head_q[IDX_W-1:0];
        tail_idx    = tail_q[IDX_W-1:0];
        occupancy   = tail_q - head_q;
        count       = occupancy;
        full        = (occupancy == PTR_W'(DEPTH));
        empty       = (head_q == tail_q);
        st_ready    = !full;
        drain_valid = entries_q[head_idx].valid && entries_q[head_idx].committed;
        drain_addr  = {entries_q[head_idx].waddr, 2'b00};
        drain_data  = entries_q[head_idx].data;
        drain_mask  = entries_q[head_idx].mask;
        drain_fire  = drain_valid && drain_ready;
    end

    // Place store data on its byte lanes and build store/load byte enables
    always_comb begin
        st_mask  = size_to_mask(st_funct3, st_addr[1:0]);
        ld_mask  = size_to_mask(ld_funct3, ld_addr[1:0]);
        st_shift = st_data << {st_addr[1:0], 3'b000};
        st_lane  = '0;
        for (int b = 0; b < SB_MASK_W; b++) begin
            st_lane[8*b +: 8] = st_mask[b] ? st_shift[8*b +: 8] : 8'h00;
        end
    end

    // Next state: commit first, then drain, then either flush rollback or insert
    always_comb begin
        entries_d      = entries_q;
        head_d         = head_q;
        tail_d         = tail_q;
        scan_idx       = '0;
        rollback_found = 1'b0;

        if (commit_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_d[i].valid && (entries_d[i].rob_id == commit_rob_id)) begin
                    entries_d[i].committed = 1'b1;
                end
            end
        end

        if (drain_fire) begin
            entries_d[head_idx].valid     = 1'b0;
            entries_d[head_idx].committed = 1'b0;
            head_d                        = head_q + PTR_W'(1);
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                scan_idx = head_idx + IDX_W'(i);
                if (!rollback_found && entries_d[scan_idx].valid &&
                    !entries_d[scan_idx].committed) begin
                    rollback_found = 1'b1;
                    tail_d         = head_q + PTR_W'(i);
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_d[i].valid && !entries_d[i].committed) begin
                    entries_d[i].valid = 1'b0;
                end
            end
        end else if (st_valid && st_ready) begin
            entries_d[tail_idx].valid     = 1'b1;
            entries_d[tail_idx].committed = 1'b0;
            entries_d[tail_idx].waddr     = st_addr[WORD_SIZE-1:2];
            entries_d[tail_idx].data      = st_lane;
            entries_d[tail_idx].mask      = st_mask;
            entries_d[tail_idx].rob_id    = st_rob_id;
            tail_d                        = tail_q + PTR_W'(1);
        end
    end

    // Pointer and entry registers, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            entries_q <= entries_d;
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd_match (
        .entries  (entries_q),
        .head     (head_idx),
        .ld_valid (ld_valid),
        .ld_waddr (ld_addr[WORD_SIZE-1:2]),
        .ld_mask  (ld_mask),
        .hit      (fwd_hit),
        .partial  (fwd_stall),
        .data     (fwd_data)
    );

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Self-checking bench for store_buffer_fwd with DEPTH=4 and 4-bit ROB tags.
module tb_store_buffer_fwd;

    localparam logic [2:0] F_B = 3'b000;
    localparam logic [2:0] F_H = 3'b001;
    localparam logic [2:0] F_W = 3'b010;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic [3:0]  st_rob_id;
    logic        commit_valid;
    logic [3:0]  commit_rob_id;
    logic        flush;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_stall;
    logic        drain_valid;
    logic        drain_ready;
    logic [31:0] drain_addr;
    logic [31:0] drain_data;
    logic [3:0]  drain_mask;
    logic        full;
    logic        empty;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic        valid;
        logic        exp_hit;
        logic        exp_stall;
        logic [31:0] exp_data;
    } fwd_vec_t;

    fwd_vec_t vecs [11];

    // 100 MHz clock
    always #5 clk = ~clk;

    store_buffer_fwd #(
        .WORD_SIZE       (32),
        .DEPTH           (4),
        .ROB_ENTRY_WIDTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_funct3     (st_funct3),
        .st_rob_id     (st_rob_id),
        .commit_valid  (commit_valid),
        .commit_rob_id (commit_rob_id),
        .flush         (flush),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_funct3     (ld_funct3),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data),
        .fwd_stall     (fwd_stall),
        .drain_valid   (drain_valid),
        .drain_ready   (drain_ready),
        .drain_addr    (drain_addr),
        .drain_data    (drain_data),
        .drain_mask    (drain_mask),
        .full          (full),
        .empty         (empty),
        .count         (count)
    );

    // Compare one observed value against its expected value and tally it
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive every store/commit/flush/drain input for the coming clock edge
    task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                 input logic [2:0] sf, input logic [3:0] srob,
                                 input logic cv, input logic [3:0] crob,
                                 input logic fl, input logic dr);
        st_valid      = sv;
        st_addr       = sa;
        st_data       = sd;
        st_funct3     = sf;
        st_rob_id     = srob;
        commit_valid  = cv;
        commit_rob_id = crob;
        flush         = fl;
        drain_ready   = dr;
        #1;
    endtask

    // Drive the load lookup port and let the forwarding path settle
    task automatic setLoad(input logic v, input logic [31:0] a, input logic [2:0] f3);
        ld_valid  = v;
        ld_addr   = a;
        ld_funct3 = f3;
        #1;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 32'h0, F_B, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic insertStore(input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] f3, input logic [3:0] rob);
        applyStimulus(1'b1, a, d, f3, rob, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    // Main sequence: reset, fill, forwarding table, drain, reset, flush, wrap
    initial begin
        bit do_ins;
        bit do_com;
        int ins;
        int com;
        int drn;

        vecs[0]  = '{"lw400 partial",   32'h400, F_W,    1'b1, 1'b0, 1'b1, 32'h0};
        vecs[1]  = '{"lb401 sb hit",    32'h401, F_B,    1'b1, 1'b1, 1'b0, 32'h0000FF00};
        vecs[2]  = '{"lb400 sw hit",    32'h400, F_B,    1'b1, 1'b1, 1'b0, 32'h11223344};
        vecs[3]  = '{"lhu402 sw hit",   32'h402, 3'b101, 1'b1, 1'b1, 1'b0, 32'h11223344};
        vecs[4]  = '{"lw404 miss",      32'h404, F_W,    1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{"lh40A sh hit",    32'h40A, F_H,    1'b1, 1'b1, 1'b0, 32'hBEEF0000};
        vecs[6]  = '{"lb409 no lap",    32'h409, F_B,    1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{"lw408 partial",   32'h408, F_W,    1'b1, 1'b0, 1'b1, 32'h0};
        vecs[8]  = '{"lw500 hit",       32'h500, F_W,    1'b1, 1'b1, 1'b0, 32'hCAFEF00D};
        vecs[9]  = '{"lbu503 hit",      32'h503, 3'b100, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D};
        vecs[10] = '{"lw500 ld off",    32'h500, F_W,    1'b0, 1'b0, 1'b0, 32'h0};

        rst = 1'b0;
        idle();
        setLoad(1'b0, 32'h0, F_B);
        repeat (2) @(posedge clk);
        #1;

        // Reset values of the flags and the handshake outputs
        checkOutput("reset empty",       32'(empty),       32'd1);
        checkOutput("reset full",        32'(full),        32'd0);
        checkOutput("reset count",       32'(count),       32'd0);
        checkOutput("reset st_ready",    32'(st_ready),    32'd1);
        checkOutput("reset drain_valid", 32'(drain_valid), 32'd0);
        checkOutput("reset fwd_hit",     32'(fwd_hit),     32'd0);
        checkOutput("reset fwd_stall",   32'(fwd_stall),   32'd0);
        rst = 1'b1;
        tick();

        // Fill all four entries, rob 0..3
        insertStore(32'h400, 32'h11223344, F_W, 4'd0);
        checkOutput("fill count1", 32'(count), 32'd1);
        insertStore(32'h401, 32'h000000FF, F_B, 4'd1);
        insertStore(32'h40A, 32'h0000BEEF, F_H, 4'd2);
        insertStore(32'h500, 32'hCAFEF00D, F_W, 4'd3);
        checkOutput("fill full",        32'(full),        32'd1);
        checkOutput("fill st_ready",    32'(st_ready),    32'd0);
        checkOutput("fill count4",      32'(count),       32'd4);
        checkOutput("fill drain_valid", 32'(drain_valid), 32'd0);

        // An extra store while full is dropped
        applyStimulus(1'b1, 32'h404, 32'h99999999, F_W, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("overfill count", 32'(count), 32'd4);
        checkOutput("overfill full",  32'(full),  32'd1);

        // Forwarding lookups against the full buffer
        for (int i = 0; i < 11; i++) begin
            setLoad(vecs[i].valid, vecs[i].addr, vecs[i].f3);
            checkOutput({vecs[i].name, " hit"},   32'(fwd_hit),   32'(vecs[i].exp_hit));
            checkOutput({vecs[i].name, " stall"}, 32'(fwd_stall), 32'(vecs[i].exp_stall));
            if (vecs[i].exp_hit) begin
                checkOutput({vecs[i].name, " data"}, fwd_data, vecs[i].exp_data);
            end
        end
        setLoad(1'b0, 32'h0, F_B);

        // Commit and drain the head word store
        applyStimulus(1'b0, 32'h0, 32'h0, F_B, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("sw drain_valid", 32'(drain_valid), 32'd1);
        checkOutput("sw drain_addr",  drain_addr,       32'h400);
        checkOutput("sw drain_data",  drain_data,       32'h11223344);
        checkOutput("sw drain_mask",  32'(drain_mask),  32'hF);
        applyStimulus(1'b0, 32'h0, 32'h0, F_B, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("post drain count",       32'(count),       32'd3);
        checkOutput("post drain drain_valid", 32'(drain_valid), 32'd0);

        // Commit rob 1 so the head is offered, then reset asynchronously mid-cycle
        applyStimulus(1'b0, 32'h0, 32'h0, F_B, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("sb drain_valid", 32'(drain_valid), 32'd1);
        checkOutput("sb drain_data",  drain_data,       32'h0000FF00);
        checkOutput("sb drain_mask",  32'(drain_mask),  32'h2);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async rst empty",       32'(empty),       32'd1);
        checkOutput("async rst count",       32'(count),       32'd0);
        checkOutput("async rst drain_valid", 32'(drain_valid), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Byte store to 0x402, committed, held against a busy cache for 3 cycles
        insertStore(32'h402, 32'h000000AB, F_B, 4'd5);
        applyStimulus(1'b0, 32'h0, 32'h0, F_B, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            checkOutput("hold drain_valid", 32'(drain_valid), 32'd1);
            checkOutput("hold drain_addr",  drain_addr,       32'h400);
            checkOutput("hold drain_mask",  32'(drain_mask),  32'h4);
            checkOutput("hold drain_data",  drain_data,       32'h00AB0000);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, F_B, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("hold release empty",       32'(empty),       32'd1);
        checkOutput("hold release drain_valid", 32'(drain_valid), 32'd0);

        // Flush with rob 4 committed in the same cycle; the insert is ignored
        for (int k = 0; k < 4; k++) begin
            insertStore(32'h600 + 32'(4 * k), 32'h60 + 32'(k), F_W, 4'(4 + k));
        end
        applyStimulus(1'b1, 32'h620, 32'h12345678, F_W, 4'd12, 1'b1, 4'd4, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("flush count",       32'(count),       32'd1);
        checkOutput("flush full",        32'(full),        32'd0);
        checkOutput("flush drain_valid", 32'(drain_valid), 32'd1);
        checkOutput("flush drain_addr",  drain_addr,       32'h600);
        checkOutput("flush drain_data",  drain_data,       32'h60);
        setLoad(1'b1, 32'h604, F_W);
        checkOutput("flushed lw604 hit",   32'(fwd_hit),   32'd0);
        checkOutput("flushed lw604 stall", 32'(fwd_stall), 32'd0);
        setLoad(1'b1, 32'h600, F_W);
        checkOutput("kept lw600 hit",  32'(fwd_hit), 32'd1);
        checkOutput("kept lw600 data", fwd_data,     32'h60);
        setLoad(1'b0, 32'h0, F_B);
        applyStimulus(1'b0, 32'h0, 32'h0, F_B, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("flush drained empty", 32'(empty), 32'd1);

        // Drain, flush and a dropped insert all in one cycle
        insertStore(32'h700, 32'h70, F_W, 4'd8);
        insertStore(32'h704, 32'h74, F_W, 4'd9);
        applyStimulus(1'b0, 32'h0, 32'h0, F_B, 4'd0, 1'b1, 4'd8, 1'b0, 1'b0);
        tick();
        idle();
        applyStimulus(1'b1, 32'h708, 32'h78, F_W, 4'd10, 1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        idle();
        checkOutput("drain+flush count", 32'(count), 32'd0);
        checkOutput("drain+flush empty", 32'(empty), 32'd1);
        setLoad(1'b1, 32'h708, F_W);
        checkOutput("dropped lw708 hit", 32'(fwd_hit), 32'd0);
        setLoad(1'b0, 32'h0, F_B);
        insertStore(32'h710, 32'h7A, F_W, 4'd11);
        checkOutput("reinsert count", 32'(count), 32'd1);
        setLoad(1'b1, 32'h710, F_W);
        checkOutput("reinsert lw710 hit",  32'(fwd_hit), 32'd1);
        checkOutput("reinsert lw710 data", fwd_data,     32'h7A);
        setLoad(1'b0, 32'h0, F_B);
        applyStimulus(1'b0, 32'h0, 32'h0, F_B, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("clear flush count", 32'(count), 32'd0);

        // Wrap-around stream: 12 stores through insert, commit and a stuttering drain
        ins = 0;
        com = 0;
        drn = 0;
        for (int cyc = 0; cyc < 300 && drn < 12; cyc++) begin
            do_ins = (ins < 12) && st_ready;
            do_com = (com < ins);
            applyStimulus(do_ins, 32'h800 + 32'(4 * ins), 32'hD0000000 + 32'(ins), F_W,
                          4'(ins), do_com, 4'(com), 1'b0, (cyc % 3) != 0);
            if (drain_valid && drain_ready) begin
                checkOutput("wrap drain order", drain_data, 32'hD0000000 + 32'(drn));
                drn++;
            end
            tick();
            if (do_ins) ins++;
            if (do_com) com++;
        end
        idle();
        checkOutput("wrap drained total", 32'(drn),   32'd12);
        checkOutput("wrap final empty",   32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
